// File: rtl/ibex_dmem_responder_pkg.sv
// Shared defaults and helpers for the data-memory responder.
package ibex_dmem_responder_pkg;

  localparam int unsigned DefMemSizeBytes   = 65536;
  localparam logic [31:0] DefBaseAddr       = 32'h0010_0000;
  localparam int unsigned DefRspLatency     = 1;
  localparam int unsigned DefMaxOutstanding = 2;

  // Replace the bytes of old_word selected by be with those of new_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ibex_dmem_rsp_fifo.sv
// In-order response queue. Every entry carries its own countdown so that
// back-to-back grants produce back-to-back responses; the head may only
// leave once its countdown has reached zero.
module ibex_dmem_rsp_fifo #(
  parameter int unsigned Depth   = 2,
  parameter int unsigned Latency = 1,
  localparam int unsigned CntW   = $clog2(Depth + 1),
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned LatW   = (Latency > 1) ? $clog2(Latency) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [31:0]     push_rdata_i,
  input  logic            push_err_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic            head_ready_o,
  output logic [31:0]     head_rdata_o,
  output logic            head_err_o,
  output logic [CntW-1:0] count_o
);

  typedef struct packed {
    logic [31:0]     rdata;
    logic            err;
    logic [LatW-1:0] cnt;
  } rsp_entry_t;

  rsp_entry_t      entries_q [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage, countdowns, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (valid_q[i] && (entries_q[i].cnt != '0)) begin
          entries_q[i].cnt <= entries_q[i].cnt - 1'b1;
        end
      end
      if (push_i) begin
        entries_q[wr_ptr_q] <= '{rdata: push_rdata_i, err: push_err_i,
                                 cnt: LatW'(Latency - 1)};
        valid_q[wr_ptr_q]   <= 1'b1;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign full_o       = (count_q == CntW'(Depth));
  assign empty_o      = (count_q == '0);
  assign head_ready_o = valid_q[rd_ptr_q] && (entries_q[rd_ptr_q].cnt == '0);
  assign head_rdata_o = entries_q[rd_ptr_q].rdata;
  assign head_err_o   = entries_q[rd_ptr_q].err;
  assign count_o      = count_q;

endmodule

// File: rtl/ibex_dmem_responder.sv
// Data-bus memory responder: grants LSU requests, performs the word access at
// the grant edge and returns in-order responses after a fixed latency.
module ibex_dmem_responder
  import ibex_dmem_responder_pkg::*;
#(
  parameter int unsigned MemSizeBytes   = DefMemSizeBytes,
  parameter logic [31:0] BaseAddr       = DefBaseAddr,
  parameter int unsigned RspLatency     = DefRspLatency,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding,
  localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [31:0]     data_addr_i,
  input  logic [31:0]     data_wdata_i,
  input  logic            stall_gnt_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [31:0]     data_rdata_o,
  output logic            data_err_o,
  output logic [OutW-1:0] outstanding_o
);

  localparam int unsigned NumWords = MemSizeBytes / 4;
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;

  logic [31:0]     mem_q [NumWords];
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] word_idx;
  logic [31:0]     rsp_rdata;
  logic            full;
  logic            empty;
  logic            head_ready;
  logic [31:0]     head_rdata;
  logic            head_err;
  logic            rsp_pop;

  // Unsigned wrap-around makes addresses below BaseAddr look huge, so one
  // compare covers both ends of the window.
  assign offset   = data_addr_i - BaseAddr;
  assign in_range = offset < 32'(MemSizeBytes);
  assign word_idx = offset[IdxW+1:2];

  // Fullness is taken before any same-cycle pop; grant is held off in reset.
  assign data_gnt_o = data_req_i & rst_ni & ~full & ~stall_gnt_i;

  assign rsp_rdata = (data_we_i || !in_range) ? '0 : mem_q[word_idx];

  // Byte-enabled store at the grant edge; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (data_gnt_o && data_we_i && in_range) begin
      mem_q[word_idx] <= be_merge(mem_q[word_idx], data_wdata_i, data_be_i);
    end
  end

  assign rsp_pop = head_ready & ~empty;

  ibex_dmem_rsp_fifo #(
    .Depth   (MaxOutstanding),
    .Latency (RspLatency)
  ) u_rsp_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (data_gnt_o),
    .push_rdata_i (rsp_rdata),
    .push_err_i   (~in_range),
    .pop_i        (rsp_pop),
    .full_o       (full),
    .empty_o      (empty),
    .head_ready_o (head_ready),
    .head_rdata_o (head_rdata),
    .head_err_o   (head_err),
    .count_o      (outstanding_o)
  );

  assign data_rvalid_o = rsp_pop;
  assign data_rdata_o  = rsp_pop ? head_rdata : '0;
  assign data_err_o    = rsp_pop & head_err;

endmodule

// File: tb/tb_ibex_dmem_responder.sv
// Bench for the data-memory responder: a latency-1 instance for the
// functional vector table and a latency-3 instance for queueing corners and
// randomized traffic against a transaction-level model.
module tb_ibex_dmem_responder;

  localparam logic [31:0] B  = 32'h0010_0000;
  localparam logic [31:0] MS = 32'd65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req, we, stall, gnt, rvalid, err;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  out;

  logic        req3, we3, stall3, gnt3, rvalid3, err3;
  logic [3:0]  be3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [1:0]  out3;

  ibex_dmem_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .stall_gnt_i(stall), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .data_err_o(err), .outstanding_o(out)
  );

  ibex_dmem_responder #(.RspLatency(3), .MaxOutstanding(2)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req3), .data_we_i(we3),
    .data_be_i(be3), .data_addr_i(addr3), .data_wdata_i(wdata3),
    .stall_gnt_i(stall3), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
    .data_rdata_o(rdata3), .data_err_o(err3), .outstanding_o(out3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic w, input logic [3:0] b, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = w; v.be = b; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    bit          known;
  } rsp_t;

  rsp_t        mq[$];
  logic [31:0] mm[int];

  logic [31:0] a_addr [4];
  logic [31:0] a_val  [4];

  int s5_g [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
  int s5_v [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
  int s5_i [10] = '{0, 0, 0, 0, 1, 0, 0, 2, 3, 0};
  int s5_o [10] = '{0, 1, 2, 2, 1, 1, 2, 2, 1, 0};

  int s7_g [11] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  int s7_v [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
  int s7_o [11] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};

  // Single transaction on the latency-3 instance with bounded waits.
  task automatic op3(input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic e);
    bit got, seen;
    int n;
    req3 = 1'b1; we3 = w; be3 = b; addr3 = a; wdata3 = d;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = gnt3;
      @(posedge clk); #1;
      n++;
    end
    req3 = 1'b0;
    chk("op3_grant_wait", 32'(got), 32'd1);
    seen = 0; n = 0; rd = '0; e = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (rvalid3) begin
        seen = 1; rd = rdata3; e = err3;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("op3_rvalid_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_v;
    logic        e_v;
    int          granted;
    int          cyc;

    rst_n = 1'b0;
    req = 1'b1; we = 1'b0; be = 4'h0; addr = B + 32'h40; wdata = '0; stall = 1'b0;
    req3 = 1'b0; we3 = 1'b0; be3 = 4'h0; addr3 = B; wdata3 = '0; stall3 = 1'b0;

    // Reset held with a request pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_out3", 32'(out3), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("release_rvalid", 32'(rvalid), 32'd1);
    chk("release_out", 32'(out), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_rvalid", 32'(rvalid), 32'd0);
    chk("idle_out", 32'(out), 32'd0);
    @(posedge clk); #1;

    // Back-to-back vector table on the latency-1 instance.
    vt.push_back(mk(1, 4'hF, B + 32'h10,    32'hDEAD_BEEF, 32'h0,          0));
    vt.push_back(mk(0, 4'h0, B + 32'h10,    32'h0,         32'hDEAD_BEEF,  0));
    vt.push_back(mk(0, 4'h0, B + 32'h13,    32'h0,         32'hDEAD_BEEF,  0));
    vt.push_back(mk(1, 4'hF, B + 32'h20,    32'h1122_3344, 32'h0,          0));
    vt.push_back(mk(1, 4'h1, B + 32'h20,    32'h0000_00AA, 32'h0,          0));
    vt.push_back(mk(0, 4'h0, B + 32'h20,    32'h0,         32'h1122_33AA,  0));
    vt.push_back(mk(1, 4'h8, B + 32'h20,    32'hBB00_0000, 32'h0,          0));
    vt.push_back(mk(0, 4'h0, B + 32'h20,    32'h0,         32'hBB22_33AA,  0));
    vt.push_back(mk(1, 4'hF, B,             32'h0102_0304, 32'h0,          0));
    vt.push_back(mk(1, 4'hF, B + 32'hFFFC,  32'h5566_7788, 32'h0,          0));
    vt.push_back(mk(0, 4'h0, B + MS,        32'h0,         32'h0,          1));
    vt.push_back(mk(0, 4'h0, B - 32'h4,     32'h0,         32'h0,          1));
    vt.push_back(mk(1, 4'hF, B + MS,        32'hFFFF_FFFF, 32'h0,          1));
    vt.push_back(mk(1, 4'hF, B - 32'h4,     32'hFFFF_FFFF, 32'h0,          1));
    vt.push_back(mk(0, 4'h0, B,             32'h0,         32'h0102_0304,  0));
    vt.push_back(mk(0, 4'h0, B + 32'hFFFC,  32'h0,         32'h5566_7788,  0));
    vt.push_back(mk(0, 4'h0, B + 32'h20,    32'h0,         32'hBB22_33AA,  0));

    for (int i = 0; i < vt.size(); i++) begin
      req = 1'b1; we = vt[i].we; be = vt[i].be; addr = vt[i].addr; wdata = vt[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'd1);
      if (i > 0) begin
        chk($sformatf("vec%0d_rvalid", i - 1), 32'(rvalid), 32'd1);
        chk($sformatf("vec%0d_rdata", i - 1), rdata, vt[i-1].exp_rdata);
        chk($sformatf("vec%0d_err", i - 1), 32'(err), 32'(vt[i-1].exp_err));
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    @(negedge clk);
    chk("vec_last_rvalid", 32'(rvalid), 32'd1);
    chk("vec_last_rdata", rdata, vt[vt.size()-1].exp_rdata);
    chk("vec_last_err", 32'(err), 32'(vt[vt.size()-1].exp_err));
    @(posedge clk); #1;

    // Preload four words in the latency-3 instance.
    for (int k = 0; k < 4; k++) begin
      a_addr[k] = B + 32'h200 + 32'(4 * k);
      a_val[k]  = 32'hA0A0_0000 + 32'(k);
      op3(1'b1, 4'hF, a_addr[k], a_val[k], rd_v, e_v);
      chk("preload_rdata", rd_v, 32'd0);
    end

    // Four loads with req held: full throttles grants, responses stay in order.
    granted = 0;
    for (int k = 0; k < 10; k++) begin
      req3 = (granted < 4); we3 = 1'b0; be3 = 4'h0;
      addr3 = a_addr[(granted < 4) ? granted : 3];
      @(negedge clk);
      chk($sformatf("full_k%0d_gnt", k), 32'(gnt3), 32'(s5_g[k]));
      chk($sformatf("full_k%0d_rvalid", k), 32'(rvalid3), 32'(s5_v[k]));
      chk($sformatf("full_k%0d_out", k), 32'(out3), 32'(s5_o[k]));
      if (s5_v[k] != 0) chk($sformatf("full_k%0d_rdata", k), rdata3, a_val[s5_i[k]]);
      if (gnt3) granted++;
      @(posedge clk); #1;
    end
    req3 = 1'b0;

    // Reset pulse with two loads in flight drops both responses.
    for (int k = 0; k < 2; k++) begin
      req3 = 1'b1; we3 = 1'b0; addr3 = a_addr[k];
      @(negedge clk);
      chk("rstmid_gnt", 32'(gnt3), 32'd1);
      @(posedge clk); #1;
    end
    req3 = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstmid_no_rvalid", 32'(rvalid3), 32'd0);
      chk("rstmid_out", 32'(out3), 32'd0);
      @(posedge clk); #1;
    end
    op3(1'b0, 4'h0, a_addr[1], 32'h0, rd_v, e_v);
    chk("rstmid_next_rdata", rd_v, a_val[1]);
    chk("rstmid_next_err", 32'(e_v), 32'd0);

    // Stall for five cycles while an earlier load drains.
    for (int k = 0; k < 11; k++) begin
      stall3 = (k >= 1 && k <= 5);
      req3   = (k <= 6);
      we3    = 1'b0;
      addr3  = (k == 0) ? a_addr[2] : a_addr[3];
      @(negedge clk);
      chk($sformatf("stall_k%0d_gnt", k), 32'(gnt3), 32'(s7_g[k]));
      chk($sformatf("stall_k%0d_rvalid", k), 32'(rvalid3), 32'(s7_v[k]));
      chk($sformatf("stall_k%0d_out", k), 32'(out3), 32'(s7_o[k]));
      if (k == 3) chk("stall_rdata_a2", rdata3, a_val[2]);
      if (k == 9) chk("stall_rdata_a3", rdata3, a_val[3]);
      @(posedge clk); #1;
    end
    stall3 = 1'b0; req3 = 1'b0;

    // Randomized traffic against a transaction-level model.
    cyc = 0;
    for (int t = 0; t < 400; t++) begin
      int          widx;
      bit          exp_g, exp_v;
      logic [31:0] off;
      rsp_t        r;
      widx   = $urandom_range(0, 9);
      req3   = (t < 390) && ($urandom_range(0, 3) != 0);
      we3    = $urandom_range(0, 1);
      be3    = 4'($urandom);
      wdata3 = $urandom;
      stall3 = ($urandom_range(0, 7) == 0);
      if (widx < 8)       addr3 = B + 32'h300 + 32'(4 * widx);
      else if (widx == 8) addr3 = B + MS + 32'h300;
      else                addr3 = B - 32'h300;
      addr3[1:0] = 2'($urandom);
      @(negedge clk);
      exp_g = req3 && !stall3 && (mq.size() < 2);
      exp_v = (mq.size() > 0) && (mq[0].due == cyc);
      chk("rand_gnt", 32'(gnt3), 32'(exp_g));
      chk("rand_rvalid", 32'(rvalid3), 32'(exp_v));
      chk("rand_out", 32'(out3), 32'(mq.size()));
      if (exp_v) begin
        if (mq[0].known) chk("rand_rdata", rdata3, mq[0].rdata);
        chk("rand_err", 32'(err3), 32'(mq[0].err));
        void'(mq.pop_front());
      end else begin
        chk("rand_idle_rdata", rdata3, 32'd0);
        chk("rand_idle_err", 32'(err3), 32'd0);
      end
      if (exp_g) begin
        off     = addr3 - B;
        r.due   = cyc + 3;
        r.err   = !(off < MS);
        r.rdata = '0;
        r.known = 1'b1;
        if (!we3 && !r.err) begin
          if (mm.exists(int'(off >> 2))) r.rdata = mm[int'(off >> 2)];
          else r.known = 1'b0;
        end
        mq.push_back(r);
        if (we3 && !r.err) begin
          if (mm.exists(int'(off >> 2))) begin
            logic [31:0] wv;
            wv = mm[int'(off >> 2)];
            for (int b = 0; b < 4; b++) if (be3[b]) wv[8*b +: 8] = wdata3[8*b +: 8];
            mm[int'(off >> 2)] = wv;
          end else if (be3 == 4'hF) begin
            mm[int'(off >> 2)] = wdata3;
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    req3 = 1'b0; stall3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
